axil_regfile_slave: RTL and testbench
=====================================

Name: axil_regfile_slave

Overview:
- AXI4-Lite responder (slave end) that terminates the axilite_int bus in a bank of NUM_REGS 32-bit control/status registers.
- Sits behind the interconnect on the slave modport. Drives register contents to fabric logic as a flat bus.
- Emits a one-cycle pulse per register on every committed write.
- Independent read and write paths; one outstanding transaction per direction.

Parameters:
- C_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_AXI_ADDR_WIDTH, 8, byte address width.
- NUM_REGS, 8, number of 32-bit registers; range 1..2^(C_AXI_ADDR_WIDTH-2).
- OPT_READ_SIDEEFFECTS, 1, enables clear-on-read of the status register; only effective with the optional feature.

Ports:
- AXI_ACLK  in  1  clock
- AXI_ARESETN  in  1  reset; asynchronous, active-low
- AXI_AWADDR  in  C_AXI_ADDR_WIDTH  write address
- AXI_AWPROT  in  3  ignored
- AXI_AWVALID  in  1
- AXI_AWREADY  out  1
- AXI_WDATA  in  C_AXI_DATA_WIDTH
- AXI_WSTRB  in  C_AXI_DATA_WIDTH/8  byte enables
- AXI_WVALID  in  1
- AXI_WREADY  out  1
- AXI_BRESP  out  2
- AXI_BVALID  out  1
- AXI_BREADY  in  1
- AXI_ARADDR  in  C_AXI_ADDR_WIDTH
- AXI_ARPROT  in  3  ignored
- AXI_ARVALID  in  1
- AXI_ARREADY  out  1
- AXI_RDATA  out  C_AXI_DATA_WIDTH
- AXI_RRESP  out  2
- AXI_RVALID  out  1
- AXI_RREADY  in  1
- regs_o  out  NUM_REGS*32  register contents; reg k occupies bits [32k+31:32k]
- wr_pulse_o  out  NUM_REGS  one-cycle commit strobe per register
- status_set_i  in  32  sticky status set bits; used only with the optional feature

Behaviour:
- Reset (AXI_ARESETN low, asynchronous) clears all of the following to 0:
  - registers, regs_o, wr_pulse_o
  - BVALID, RVALID, BRESP, RRESP, RDATA
  - aw_held, w_held
- AWREADY, WREADY and ARREADY are combinationally forced to 0 while AXI_ARESETN is low.
- Reset mid-transaction drops any captured AW/W and any pending B/R response; no register update occurs.
- Decode:
  - Word index = ADDR[C_AXI_ADDR_WIDTH-1:2]; ADDR[1:0] is ignored.
  - Index < NUM_REGS returns OKAY (2'b00).
  - Otherwise returns SLVERR (2'b10); writes are discarded and RDATA=0.
- Write path:
  - AWREADY = !aw_held; WREADY = !w_held.
  - Each channel captures into a 1-entry hold register on its handshake. AW and W may arrive in any order or in the same cycle.
  - A write commits on the edge where aw_held && w_held && (!BVALID || BREADY).
  - On commit: byte lanes with WSTRB=1 update, others keep their value; BRESP is set; BVALID rises; both held flags clear; wr_pulse_o[idx] is high for exactly the next cycle (not on SLVERR).
  - Latency: second of AW/W accepted in cycle c → register and BVALID updated in cycle c+2.
  - BVALID holds with a stable BRESP until BREADY. A back-pressured B stalls the next commit; the held AW/W stay held.
- Read path:
  - ARREADY = !RVALID || RREADY.
  - Accepted in cycle c → RVALID, RDATA and RRESP are registered in cycle c+1 and stable until RREADY.
  - Back-to-back reads sustain one per cycle when RREADY is held high.
- Read and write commit on the same edge to the same register: read returns the pre-write value.
- WSTRB=0 with a valid address: OKAY response, no data change, wr_pulse_o still fires.

Optional Feature:
- Macro: AXIL_REGFILE_STATUS_EN.
- Defined: register NUM_REGS-1 is a sticky status register.
  - Every cycle: reg |= status_set_i.
  - AXI writes to it are write-1-to-clear per strobed byte.
  - If OPT_READ_SIDEEFFECTS=1, a read clears exactly the bits returned in RDATA on the accept edge.
  - A set and a clear on the same edge: set wins.
- Not defined: register NUM_REGS-1 is an ordinary R/W register and status_set_i is ignored.

Test Plan:
- Reset, then AW+W same cycle to addr 0x04, data 0xDEADBEEF, WSTRB 0xF → BVALID two cycles later with BRESP 00; regs_o[63:32]=0xDEADBEEF; wr_pulse_o[1] high for 1 cycle.
- W issued 3 cycles before AW to 0x08, data 0x11223344, WSTRB 0x5, over prior 0xFFFFFFFF → register reads 0xFF22FF44; read of 0x08 returns RRESP 00.
- Write to 0x20 (index 8, NUM_REGS=8) → BRESP 10, no regs_o change, no pulse; read of 0x20 → RDATA 0, RRESP 10.
- BREADY low 5 cycles with a second AW/W pair offered → second pair captured, AWREADY/WREADY then 0; second commit only after first B handshake.
- RREADY held high, ARVALID continuous to 0x00/0x04/0x08 → RVALID every cycle, data in order; drop RREADY mid-burst → RDATA stable, ARREADY 0.
- With AXIL_REGFILE_STATUS_EN: pulse status_set_i=0x3, read reg 7 → 0x3, next read → 0; set bit 0 on the read-accept edge → bit 0 survives; write 0x2 → clears bit 1 only.

Source files
------------

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite responder terminating in NUM_REGS 32-bit control/status registers.
// Define AXIL_REGFILE_STATUS_EN to turn the top register into a sticky W1C status register.
module axil_regfile_slave #(
    parameter int C_AXI_DATA_WIDTH     = 32,
    parameter int C_AXI_ADDR_WIDTH     = 8,
    parameter int NUM_REGS             = 8,
    parameter int OPT_READ_SIDEEFFECTS = 1
) (
    input  logic                            AXI_ACLK,
    input  logic                            AXI_ARESETN,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     AXI_AWADDR,
    input  logic [2:0]                      AXI_AWPROT,
    input  logic                            AXI_AWVALID,
    output logic                            AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]     AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]   AXI_WSTRB,
    input  logic                            AXI_WVALID,
    output logic                            AXI_WREADY,
    output logic [1:0]                      AXI_BRESP,
    output logic                            AXI_BVALID,
    input  logic                            AXI_BREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]     AXI_ARADDR,
    input  logic [2:0]                      AXI_ARPROT,
    input  logic                            AXI_ARVALID,
    output logic                            AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]     AXI_RDATA,
    output logic [1:0]                      AXI_RRESP,
    output logic                            AXI_RVALID,
    input  logic                            AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          regs_o,
    output logic [NUM_REGS-1:0]             wr_pulse_o,
    input  logic [31:0]                     status_set_i
);
    localparam int DW   = C_AXI_DATA_WIDTH;
    localparam int SW   = DW / 8;
    localparam int IDXW = C_AXI_ADDR_WIDTH - 2;
    localparam logic [IDXW:0] NUM_REGS_W = (IDXW+1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_REGFILE_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif
    localparam bit RD_CLR_EN = STATUS_EN && (OPT_READ_SIDEEFFECTS != 0);

    logic                       aw_held;
    logic                       w_held;
    logic [IDXW-1:0]            aw_idx_q;
    logic [DW-1:0]              w_data_q;
    logic [SW-1:0]              w_strb_q;
    logic [DW-1:0]              wr_mask;
    logic                       bvalid_q;
    logic [1:0]                 bresp_q;
    logic                       rvalid_q;
    logic [1:0]                 rresp_q;
    logic [DW-1:0]              rdata_q;
    logic [NUM_REGS-1:0]        wr_sel;
    logic [NUM_REGS-1:0]        rd_sel;
    logic [NUM_REGS-1:0]        wr_pulse_q;
    logic [NUM_REGS-1:0][DW-1:0] reg_vals;
    logic [IDXW-1:0]            ar_idx;
    logic [DW-1:0]              rd_mux;
    logic                       aw_ok;
    logic                       ar_ok;
    logic                       aw_fire;
    logic                       w_fire;
    logic                       ar_fire;
    logic                       commit;

    assign AXI_AWREADY = AXI_ARESETN && !aw_held;
    assign AXI_WREADY  = AXI_ARESETN && !w_held;
    assign AXI_ARREADY = AXI_ARESETN && (!rvalid_q || AXI_RREADY);

    assign aw_fire = AXI_AWVALID && AXI_AWREADY;
    assign w_fire  = AXI_WVALID && AXI_WREADY;
    assign ar_fire = AXI_ARVALID && AXI_ARREADY;
    assign commit  = aw_held && w_held && (!bvalid_q || AXI_BREADY);

    assign ar_idx = AXI_ARADDR[C_AXI_ADDR_WIDTH-1:2];
    assign aw_ok  = ({1'b0, aw_idx_q} < NUM_REGS_W);
    assign ar_ok  = ({1'b0, ar_idx} < NUM_REGS_W);

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < SW; b++) begin
            wr_mask[8*b +: 8] = {8{w_strb_q[b]}};
        end
    end

    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            wr_sel[k] = commit && aw_ok && (aw_idx_q == IDXW'(k));
            rd_sel[k] = ar_fire && ar_ok && (ar_idx == IDXW'(k));
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_idx == IDXW'(k)) begin
                rd_mux = reg_vals[k];
            end
        end
    end

    // AW and W each park in a one-entry hold until both are present and B is free.
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            aw_held  <= 1'b0;
            aw_idx_q <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
        end else if (aw_fire) begin
            aw_held  <= 1'b1;
            aw_idx_q <= AXI_AWADDR[C_AXI_ADDR_WIDTH-1:2];
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            w_held <= 1'b0;
        end else if (w_fire) begin
            w_held   <= 1'b1;
            w_data_q <= AXI_WDATA;
            w_strb_q <= AXI_WSTRB;
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_sel;
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_fire) begin
            rvalid_q <= 1'b1;
            rresp_q  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= ar_ok ? rd_mux : '0;
        end else if (AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        logic [DW-1:0] q;
        if (STATUS_EN && (k == NUM_REGS - 1)) begin : g_status
            logic [DW-1:0] clr;
            // Reads clear what they return; the set term is applied last so it wins.
            always_comb begin
                clr = '0;
                if (wr_sel[k]) begin
                    clr = clr | (w_data_q & wr_mask);
                end
                if (RD_CLR_EN && rd_sel[k]) begin
                    clr = clr | q;
                end
            end
            always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
                if (!AXI_ARESETN) begin
                    q <= '0;
                end else begin
                    q <= (q & ~clr) | status_set_i;
                end
            end
        end else begin : g_plain
            always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
                if (!AXI_ARESETN) begin
                    q <= '0;
                end else if (wr_sel[k]) begin
                    q <= (q & ~wr_mask) | (w_data_q & wr_mask);
                end
            end
        end
        assign reg_vals[k] = q;
    end

    assign regs_o     = reg_vals;
    assign wr_pulse_o = wr_pulse_q;
    assign AXI_BVALID = bvalid_q;
    assign AXI_BRESP  = bresp_q;
    assign AXI_RVALID = rvalid_q;
    assign AXI_RRESP  = rresp_q;
    assign AXI_RDATA  = rdata_q;

    logic unused_ok;
    assign unused_ok = ^{AXI_AWPROT, AXI_ARPROT, AXI_AWADDR[1:0], AXI_ARADDR[1:0],
                         status_set_i, rd_sel, RD_CLR_EN};

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Self-checking bench for axil_regfile_slave against a word-array reference model.
`timescale 1ns/1ps
module tb_axil_regfile_slave;
    localparam int NR = 8;
`ifdef AXIL_REGFILE_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic              AXI_ACLK = 1'b0;
    logic              AXI_ARESETN = 1'b0;
    logic [7:0]        AXI_AWADDR = '0;
    logic [2:0]        AXI_AWPROT = '0;
    logic              AXI_AWVALID = 1'b0;
    logic              AXI_AWREADY;
    logic [31:0]       AXI_WDATA = '0;
    logic [3:0]        AXI_WSTRB = '0;
    logic              AXI_WVALID = 1'b0;
    logic              AXI_WREADY;
    logic [1:0]        AXI_BRESP;
    logic              AXI_BVALID;
    logic              AXI_BREADY = 1'b0;
    logic [7:0]        AXI_ARADDR = '0;
    logic [2:0]        AXI_ARPROT = '0;
    logic              AXI_ARVALID = 1'b0;
    logic              AXI_ARREADY;
    logic [31:0]       AXI_RDATA;
    logic [1:0]        AXI_RRESP;
    logic              AXI_RVALID;
    logic              AXI_RREADY = 1'b0;
    logic [NR*32-1:0]  regs_o;
    logic [NR-1:0]     wr_pulse_o;
    logic [31:0]       status_set_i = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] mregs [NR];

    always #5 AXI_ACLK = ~AXI_ACLK;

    axil_regfile_slave #(
        .C_AXI_DATA_WIDTH(32), .C_AXI_ADDR_WIDTH(8), .NUM_REGS(NR), .OPT_READ_SIDEEFFECTS(1)
    ) dut (
        .AXI_ACLK(AXI_ACLK), .AXI_ARESETN(AXI_ARESETN),
        .AXI_AWADDR(AXI_AWADDR), .AXI_AWPROT(AXI_AWPROT), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
        .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
        .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
        .AXI_ARADDR(AXI_ARADDR), .AXI_ARPROT(AXI_ARPROT), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .status_set_i(status_set_i)
    );

    // Reference model: the register file is a plain array indexed by addr/4.
    function automatic void model_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr[7:2]);
        if (idx >= NR) return;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                if (STATUS && idx == NR - 1) mregs[idx][8*b +: 8] = mregs[idx][8*b +: 8] & ~data[8*b +: 8];
                else                         mregs[idx][8*b +: 8] = data[8*b +: 8];
            end
        end
    endfunction

    function automatic void model_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int idx;
        idx = int'(addr[7:2]);
        if (idx >= NR) begin
            data = 32'h0;
            resp = 2'b10;
        end else begin
            data = mregs[idx];
            resp = 2'b00;
            if (STATUS && idx == NR - 1) mregs[idx] = 32'h0;
        end
    endfunction

    task automatic write_txn(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly);
        int acc_n;
        bit aw_pend, w_pend, done;
        logic [1:0] exp_resp;
        logic [NR-1:0] exp_pulse;
        int idx;
        idx = int'(addr[7:2]);
        exp_resp = (idx < NR) ? 2'b00 : 2'b10;
        exp_pulse = (idx < NR) ? NR'(1) << idx : '0;
        aw_pend = 1; w_pend = 1; done = 0; acc_n = -1;
        AXI_BREADY = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge AXI_ACLK);
            if (AXI_BVALID) begin
                done = 1;
                model_write(addr, data, strb);
                checks++;
                if (acc_n < 0 || n != acc_n + 2 || AXI_BRESP !== exp_resp) begin
                    errors++;
                    $display("FAIL write_b addr=%h: got bresp=%b at cycle %0d, required bresp=%b at cycle %0d",
                             addr, AXI_BRESP, n, exp_resp, acc_n + 2);
                end
                checks++;
                if (wr_pulse_o !== exp_pulse) begin
                    errors++;
                    $display("FAIL write_pulse addr=%h: got %b required %b", addr, wr_pulse_o, exp_pulse);
                end
                for (int k = 0; k < NR; k++) begin
                    checks++;
                    if (regs_o[32*k +: 32] !== mregs[k]) begin
                        errors++;
                        $display("FAIL write_regs reg%0d: got %h required %h", k, regs_o[32*k +: 32], mregs[k]);
                    end
                end
            end
            AXI_AWVALID = aw_pend && (n >= aw_dly);
            AXI_AWADDR  = addr;
            AXI_WVALID  = w_pend && (n >= w_dly);
            AXI_WDATA   = data;
            AXI_WSTRB   = strb;
            #1;
            if (AXI_AWVALID && AXI_AWREADY) aw_pend = 0;
            if (AXI_WVALID && AXI_WREADY) w_pend = 0;
            if (!aw_pend && !w_pend && acc_n < 0) acc_n = n;
        end
        AXI_AWVALID = 1'b0;
        AXI_WVALID  = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL write_timeout addr=%h: got no BVALID, required BVALID", addr);
        end
        @(negedge AXI_ACLK);
        checks++;
        if (wr_pulse_o !== '0 || AXI_BVALID !== 1'b0) begin
            errors++;
            $display("FAIL write_after addr=%h: got pulse=%b bvalid=%b required 0/0", addr, wr_pulse_o, AXI_BVALID);
        end
    endtask

    task automatic read_txn(input logic [7:0] addr, input int ar_dly);
        int acc_n;
        bit pend, done;
        logic [31:0] exp_d;
        logic [1:0] exp_r;
        pend = 1; done = 0; acc_n = -1;
        AXI_RREADY = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge AXI_ACLK);
            if (AXI_RVALID) begin
                done = 1;
                model_read(addr, exp_d, exp_r);
                checks++;
                if (acc_n < 0 || n != acc_n + 1 || AXI_RDATA !== exp_d || AXI_RRESP !== exp_r) begin
                    errors++;
                    $display("FAIL read addr=%h: got data=%h resp=%b cycle %0d, required data=%h resp=%b cycle %0d",
                             addr, AXI_RDATA, AXI_RRESP, n, exp_d, exp_r, acc_n + 1);
                end
            end
            AXI_ARVALID = pend && (n >= ar_dly);
            AXI_ARADDR  = addr;
            #1;
            if (AXI_ARVALID && AXI_ARREADY) begin
                pend = 0;
                acc_n = n;
            end
        end
        AXI_ARVALID = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL read_timeout addr=%h: got no RVALID, required RVALID", addr);
        end
    endtask

    task automatic test_reset();
        AXI_ARESETN = 1'b0;
        repeat (2) @(negedge AXI_ACLK);
        checks++;
        if ({AXI_AWREADY, AXI_WREADY, AXI_ARREADY} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b required 000", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY});
        end
        checks++;
        if ({AXI_BVALID, AXI_RVALID, AXI_BRESP, AXI_RRESP} !== 6'b0 || AXI_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp: got bv=%b rv=%b br=%b rr=%b rd=%h required zeros",
                     AXI_BVALID, AXI_RVALID, AXI_BRESP, AXI_RRESP, AXI_RDATA);
        end
        checks++;
        if (regs_o !== '0 || wr_pulse_o !== '0) begin
            errors++;
            $display("FAIL reset_regs: got regs=%h pulse=%b required 0", regs_o, wr_pulse_o);
        end
        AXI_ARESETN = 1'b1;
        for (int k = 0; k < NR; k++) mregs[k] = 32'h0;
        @(negedge AXI_ACLK);
        checks++;
        if ({AXI_AWREADY, AXI_WREADY, AXI_ARREADY} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 111", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY});
        end
        // Capture both halves of a write, then reset before it can commit.
        AXI_AWVALID = 1'b1; AXI_AWADDR = 8'h00;
        AXI_WVALID = 1'b1; AXI_WDATA = 32'h12345678; AXI_WSTRB = 4'hF; AXI_BREADY = 1'b1;
        @(posedge AXI_ACLK);
        #2 AXI_ARESETN = 1'b0;
        #1;
        checks++;
        if ({AXI_AWREADY, AXI_WREADY, AXI_ARREADY} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_ready: got %b required 000", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY});
        end
        @(negedge AXI_ACLK);
        AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
        repeat (2) @(negedge AXI_ACLK);
        AXI_ARESETN = 1'b1;
        repeat (2) begin
            @(negedge AXI_ACLK);
            checks++;
            if (regs_o !== '0 || AXI_BVALID !== 1'b0 || AXI_AWREADY !== 1'b1 || AXI_WREADY !== 1'b1) begin
                errors++;
                $display("FAIL midreset_drop: got regs=%h bv=%b awr=%b wr=%b required 0/0/1/1",
                         regs_o, AXI_BVALID, AXI_AWREADY, AXI_WREADY);
            end
        end
    endtask

    task automatic test_write_basic();
        write_txn(8'h04, 32'hDEADBEEF, 4'hF, 0, 0);
        checks++;
        if (regs_o[63:32] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_reg1: got %h required deadbeef", regs_o[63:32]);
        end
    endtask

    task automatic test_w_before_aw();
        write_txn(8'h08, 32'hFFFFFFFF, 4'hF, 0, 0);
        write_txn(8'h08, 32'h11223344, 4'h5, 3, 0);
        checks++;
        if (regs_o[95:64] !== 32'hFF22FF44) begin
            errors++;
            $display("FAIL strobe_merge: got %h required ff22ff44", regs_o[95:64]);
        end
        read_txn(8'h08, 0);
        read_txn(8'h0B, 1);
    endtask

    task automatic test_slverr();
        write_txn(8'h20, 32'hCAFEF00D, 4'hF, 0, 0);
        read_txn(8'h20, 0);
        write_txn(8'hFC, 32'h55AA55AA, 4'hF, 1, 2);
        read_txn(8'hFC, 0);
    endtask

    task automatic test_wstrb_zero();
        write_txn(8'h0C, 32'hA5A5A5A5, 4'hF, 0, 0);
        write_txn(8'h0C, 32'h00000000, 4'h0, 0, 0);
        read_txn(8'h0C, 0);
    endtask

    task automatic test_b_stall();
        logic [31:0] d1, d2;
        d1 = $urandom;
        d2 = $urandom;
        @(negedge AXI_ACLK);
        AXI_BREADY = 1'b0;
        AXI_AWVALID = 1'b1; AXI_AWADDR = 8'h0C;
        AXI_WVALID = 1'b1; AXI_WDATA = d1; AXI_WSTRB = 4'hF;
        @(negedge AXI_ACLK);
        AXI_AWADDR = 8'h10; AXI_WDATA = d2;
        checks++;
        if (AXI_AWREADY !== 1'b0 || AXI_WREADY !== 1'b0) begin
            errors++;
            $display("FAIL stall_held1: got awr=%b wr=%b required 0/0", AXI_AWREADY, AXI_WREADY);
        end
        @(negedge AXI_ACLK);
        model_write(8'h0C, d1, 4'hF);
        checks++;
        if (AXI_BVALID !== 1'b1 || AXI_AWREADY !== 1'b1 || wr_pulse_o !== 8'h08 || regs_o[127:96] !== mregs[3]) begin
            errors++;
            $display("FAIL stall_first: got bv=%b awr=%b pulse=%b reg3=%h required 1/1/00001000/%h",
                     AXI_BVALID, AXI_AWREADY, wr_pulse_o, regs_o[127:96], mregs[3]);
        end
        @(negedge AXI_ACLK);
        AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (AXI_AWREADY !== 1'b0 || AXI_WREADY !== 1'b0 || AXI_BVALID !== 1'b1 || AXI_BRESP !== 2'b00 ||
                regs_o[159:128] !== mregs[4] || wr_pulse_o !== '0) begin
                errors++;
                $display("FAIL stall_hold%0d: got awr=%b wr=%b bv=%b br=%b reg4=%h pulse=%b required 0/0/1/00/%h/0",
                         i, AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_BRESP, regs_o[159:128], wr_pulse_o, mregs[4]);
            end
            @(negedge AXI_ACLK);
        end
        AXI_BREADY = 1'b1;
        @(negedge AXI_ACLK);
        model_write(8'h10, d2, 4'hF);
        checks++;
        if (AXI_BVALID !== 1'b1 || regs_o[159:128] !== mregs[4] || wr_pulse_o !== 8'h10) begin
            errors++;
            $display("FAIL stall_second: got bv=%b reg4=%h pulse=%b required 1/%h/00010000",
                     AXI_BVALID, regs_o[159:128], wr_pulse_o, mregs[4]);
        end
        @(negedge AXI_ACLK);
        checks++;
        if (AXI_BVALID !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: got bv=%b required 0", AXI_BVALID);
        end
    endtask

    task automatic test_read_burst();
        logic [31:0] exp_d;
        logic [1:0] exp_r;
        @(negedge AXI_ACLK);
        AXI_RREADY = 1'b1;
        AXI_ARVALID = 1'b1;
        AXI_ARADDR = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge AXI_ACLK);
            model_read(8'(4 * i), exp_d, exp_r);
            checks++;
            if (AXI_RVALID !== 1'b1 || AXI_RDATA !== exp_d || AXI_RRESP !== exp_r) begin
                errors++;
                $display("FAIL burst_beat%0d: got rv=%b data=%h resp=%b required 1/%h/%b",
                         i, AXI_RVALID, AXI_RDATA, AXI_RRESP, exp_d, exp_r);
            end
            AXI_ARADDR = 8'(4 * (i + 1));
        end
        AXI_RREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (AXI_ARREADY !== 1'b0 || AXI_RVALID !== 1'b1 || AXI_RDATA !== exp_d) begin
                errors++;
                $display("FAIL burst_stall%0d: got arr=%b rv=%b data=%h required 0/1/%h",
                         i, AXI_ARREADY, AXI_RVALID, AXI_RDATA, exp_d);
            end
            @(negedge AXI_ACLK);
        end
        AXI_RREADY = 1'b1;
        @(negedge AXI_ACLK);
        AXI_ARVALID = 1'b0;
        model_read(8'h0C, exp_d, exp_r);
        checks++;
        if (AXI_RVALID !== 1'b1 || AXI_RDATA !== exp_d) begin
            errors++;
            $display("FAIL burst_resume: got rv=%b data=%h required 1/%h", AXI_RVALID, AXI_RDATA, exp_d);
        end
        @(negedge AXI_ACLK);
        checks++;
        if (AXI_RVALID !== 1'b0) begin
            errors++;
            $display("FAIL burst_drain: got rv=%b required 0", AXI_RVALID);
        end
    endtask

    task automatic test_collision();
        logic [31:0] old_v, new_v;
        write_txn(8'h18, $urandom, 4'hF, 0, 0);
        old_v = mregs[6];
        new_v = ~old_v;
        @(negedge AXI_ACLK);
        AXI_BREADY = 1'b1; AXI_RREADY = 1'b1;
        AXI_AWVALID = 1'b1; AXI_AWADDR = 8'h18;
        AXI_WVALID = 1'b1; AXI_WDATA = new_v; AXI_WSTRB = 4'hF;
        @(negedge AXI_ACLK);
        AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
        AXI_ARVALID = 1'b1; AXI_ARADDR = 8'h18;
        @(negedge AXI_ACLK);
        AXI_ARVALID = 1'b0;
        model_write(8'h18, new_v, 4'hF);
        checks++;
        if (AXI_RVALID !== 1'b1 || AXI_RDATA !== old_v || AXI_BVALID !== 1'b1 ||
            regs_o[223:192] !== mregs[6] || wr_pulse_o !== 8'h40) begin
            errors++;
            $display("FAIL collision: got rv=%b rdata=%h bv=%b reg6=%h pulse=%b required 1/%h/1/%h/01000000",
                     AXI_RVALID, AXI_RDATA, AXI_BVALID, regs_o[223:192], wr_pulse_o, old_v, mregs[6]);
        end
        @(negedge AXI_ACLK);
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int i = 0; i < 40; i++) begin
            a = 8'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                write_txn(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
            else
                read_txn(a, $urandom_range(0, 2));
        end
    endtask

`ifdef AXIL_REGFILE_STATUS_EN
    task automatic test_status();
        write_txn(8'h1C, 32'hFFFFFFFF, 4'hF, 0, 0);
        @(negedge AXI_ACLK);
        status_set_i = 32'h3;
        @(negedge AXI_ACLK);
        status_set_i = 32'h0;
        mregs[7] = mregs[7] | 32'h3;
        checks++;
        if (regs_o[255:224] !== 32'h3) begin
            errors++;
            $display("FAIL status_set: got %h required 00000003", regs_o[255:224]);
        end
        read_txn(8'h1C, 0);
        read_txn(8'h1C, 0);
        @(negedge AXI_ACLK);
        status_set_i = 32'h1;
        @(negedge AXI_ACLK);
        mregs[7] = 32'h1;
        AXI_RREADY = 1'b1; AXI_ARVALID = 1'b1; AXI_ARADDR = 8'h1C;
        @(negedge AXI_ACLK);
        AXI_ARVALID = 1'b0;
        status_set_i = 32'h0;
        checks++;
        if (AXI_RVALID !== 1'b1 || AXI_RDATA !== 32'h1 || regs_o[255:224] !== 32'h1) begin
            errors++;
            $display("FAIL status_set_wins: got rv=%b rdata=%h reg7=%h required 1/00000001/00000001",
                     AXI_RVALID, AXI_RDATA, regs_o[255:224]);
        end
        read_txn(8'h1C, 0);
        @(negedge AXI_ACLK);
        status_set_i = 32'h3;
        @(negedge AXI_ACLK);
        status_set_i = 32'h0;
        mregs[7] = 32'h3;
        write_txn(8'h1C, 32'h2, 4'hF, 0, 0);
        checks++;
        if (regs_o[255:224] !== 32'h1) begin
            errors++;
            $display("FAIL status_w1c: got %h required 00000001", regs_o[255:224]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_w_before_aw();
        test_slverr();
        test_wstrb_zero();
        test_b_stall();
        test_read_burst();
        test_collision();
        test_random();
`ifdef AXIL_REGFILE_STATUS_EN
        test_status();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
